ad9653_bitslip_align: RTL and testbench

- Word-alignment controller directly downstream of the AD9653 LVDS deserializer front-end. Runs in the same clk_div domain as the deserializer outputs.
- With the ADC in a known test-pattern mode, it compares each lane's 8-bit deserialized word against the expected pattern. On mismatch it issues bitslip pulses until the lane matches or all 8 phases have been tried.
- Reports per-lane status and overall lock. Drives the deserializer's bitslip input vector.

---
 rtl/ad9653_bitslip_align.sv | 204 ++++++++++++++++++++
 tb/tb_ad9653_bitslip_align.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9653_bitslip_align.sv
// Word-alignment controller for the AD9653 deserializer: walks each lane, slipping until the
// test pattern is seen. Optional post-lock monitor: AD9653_BITSLIP_ALIGN_MONITOR_EN.
module ad9653_bitslip_align #(
  parameter int NLANE     = 8,
  parameter int SETTLE    = 16,
  parameter int MATCH_CNT = 8,
  parameter int PULSE_W   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [8*NLANE-1:0]   dout,
  input  logic [8*NLANE-1:0]   pattern,
  output logic [NLANE-1:0]     bitslip,
  output logic                 busy,
  output logic                 done,
  output logic                 locked,
  output logic [NLANE-1:0]     lane_ok,
  output logic [3*NLANE-1:0]   slip_cnt
`ifdef AD9653_BITSLIP_ALIGN_MONITOR_EN
  ,
  output logic [15:0]          err_cnt
`endif
);

  localparam int LW = (NLANE > 1) ? $clog2(NLANE) : 1;
  localparam int MW = $clog2(MATCH_CNT + 1);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int PW = $clog2(PULSE_W + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CHECK  = 3'd1;
  localparam logic [2:0] ST_SLIP   = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_NEXT   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  logic [2:0]         state_reg;
  logic               start_q;
  logic [8*NLANE-1:0] pat_reg;
  logic [LW-1:0]      lane_reg;
  logic [MW-1:0]      match_reg;
  logic [PW-1:0]      pulse_reg;
  logic [SW-1:0]      settle_reg;
  logic [NLANE-1:0]   bitslip_reg;
  logic [3*NLANE-1:0] slip_reg;
  logic [NLANE-1:0]   lane_ok_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               locked_reg;

  logic [NLANE-1:0]   lane_match;
  logic [NLANE-1:0]   lane_sel;
  logic [2:0]         slip_arr [NLANE];
  logic               start_edge;
  logic               cur_match;
  logic [2:0]         cur_slip;

`ifdef AD9653_BITSLIP_ALIGN_MONITOR_EN
  logic               mon_active_reg;
  logic [15:0]        err_cnt_reg;
  assign err_cnt = err_cnt_reg;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NLANE; gi++) begin : g_lane
      assign lane_match[gi] = (dout[8*gi +: 8] == pat_reg[8*gi +: 8]);
      assign lane_sel[gi]   = (lane_reg == LW'(gi));
      assign slip_arr[gi]   = slip_reg[3*gi +: 3];
    end
  endgenerate

  // start is sampled against its previous value, so a level held high starts only one run
  assign start_edge = (state_reg == ST_IDLE) && start && !start_q;
  assign cur_match  = lane_match[lane_reg];
  assign cur_slip   = slip_arr[lane_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      start_q     <= 1'b0;
      pat_reg     <= '0;
      lane_reg    <= '0;
      match_reg   <= '0;
      pulse_reg   <= '0;
      settle_reg  <= '0;
      bitslip_reg <= '0;
      slip_reg    <= '0;
      lane_ok_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      locked_reg  <= 1'b0;
`ifdef AD9653_BITSLIP_ALIGN_MONITOR_EN
      mon_active_reg <= 1'b0;
      err_cnt_reg    <= '0;
`endif
    end else begin
      start_q  <= start;
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_edge) begin
            pat_reg     <= pattern;
            lane_ok_reg <= '0;
            slip_reg    <= '0;
            locked_reg  <= 1'b0;
            lane_reg    <= '0;
            match_reg   <= '0;
            busy_reg    <= 1'b1;
            state_reg   <= ST_CHECK;
`ifdef AD9653_BITSLIP_ALIGN_MONITOR_EN
            mon_active_reg <= 1'b0;
            err_cnt_reg    <= '0;
`endif
          end
`ifdef AD9653_BITSLIP_ALIGN_MONITOR_EN
          else if (mon_active_reg) begin
            lane_ok_reg <= lane_ok_reg & lane_match;
            if (!(&lane_match)) begin
              locked_reg <= 1'b0;
              if (err_cnt_reg != 16'hFFFF) err_cnt_reg <= err_cnt_reg + 16'd1;
            end
          end
`endif
        end

        ST_CHECK: begin
          if (cur_match) begin
            if (match_reg == MW'(MATCH_CNT - 1)) begin
              lane_ok_reg <= lane_ok_reg | lane_sel;
              state_reg   <= ST_NEXT;
            end else begin
              match_reg <= match_reg + 1'b1;
            end
          end else begin
            // Pulse is launched here so bitslip is high for exactly the SLIP cycles;
            // an exhausted lane enters SLIP with bitslip low and falls through to NEXT.
            match_reg <= '0;
            pulse_reg <= '0;
            state_reg <= ST_SLIP;
            if (cur_slip != 3'd7) begin
              bitslip_reg <= lane_sel;
              for (int i = 0; i < NLANE; i++) begin
                if (lane_sel[i]) slip_reg[3*i +: 3] <= cur_slip + 3'd1;
              end
            end
          end
        end

        ST_SLIP: begin
          if (bitslip_reg == '0) begin
            state_reg <= ST_NEXT;
          end else if (pulse_reg == PW'(PULSE_W - 1)) begin
            bitslip_reg <= '0;
            settle_reg  <= '0;
            state_reg   <= ST_SETTLE;
          end else begin
            pulse_reg <= pulse_reg + 1'b1;
          end
        end

        ST_SETTLE: begin
          if (settle_reg == SW'(SETTLE - 1)) begin
            match_reg <= '0;
            state_reg <= ST_CHECK;
          end else begin
            settle_reg <= settle_reg + 1'b1;
          end
        end

        ST_NEXT: begin
          if (lane_reg == LW'(NLANE - 1)) begin
            state_reg <= ST_DONE;
          end else begin
            lane_reg  <= lane_reg + 1'b1;
            match_reg <= '0;
            state_reg <= ST_CHECK;
          end
        end

        ST_DONE: begin
          done_reg   <= 1'b1;
          busy_reg   <= 1'b0;
          locked_reg <= &lane_ok_reg;
          state_reg  <= ST_IDLE;
`ifdef AD9653_BITSLIP_ALIGN_MONITOR_EN
          mon_active_reg <= &lane_ok_reg;
`endif
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bitslip  = bitslip_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign locked   = locked_reg;
  assign lane_ok  = lane_ok_reg;
  assign slip_cnt = slip_reg;

endmodule

// File: tb/tb_ad9653_bitslip_align.sv
// Bench for ad9653_bitslip_align: a rotating-deserializer model feeds dout, and expected slips,
// flags and run length are derived from the pattern rotations the model presents.
module tb_ad9653_bitslip_align;

  localparam int NLANE     = 8;
  localparam int SETTLE    = 16;
  localparam int MATCH_CNT = 8;
  localparam int PULSE_W   = 2;
  localparam int SLIP_COST = PULSE_W + SETTLE + 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [8*NLANE-1:0]   dout;
  logic [8*NLANE-1:0]   pattern = '0;
  logic [NLANE-1:0]     bitslip;
  logic                 busy;
  logic                 done;
  logic                 locked;
  logic [NLANE-1:0]     lane_ok;
  logic [3*NLANE-1:0]   slip_cnt;
`ifdef AD9653_BITSLIP_ALIGN_MONITOR_EN
  logic [15:0]          err_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  ad9653_bitslip_align #(
    .NLANE(NLANE), .SETTLE(SETTLE), .MATCH_CNT(MATCH_CNT), .PULSE_W(PULSE_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dout(dout), .pattern(pattern),
    .bitslip(bitslip), .busy(busy), .done(done), .locked(locked),
    .lane_ok(lane_ok), .slip_cnt(slip_cnt)
`ifdef AD9653_BITSLIP_ALIGN_MONITOR_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Deserializer model: each lane shows its pattern rotated; every bitslip rising edge rotates back one bit.
  logic [7:0]       pat_m     [NLANE];
  logic [2:0]       base_rot  [NLANE];
  logic             force_en  [NLANE];
  logic [7:0]       force_val [NLANE];
  logic [NLANE-1:0] bs_q = '0;
  logic [2:0]       seen [NLANE] = '{default: 3'd0};

  function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] r);
    logic [15:0] d;
    d = {x, x} << r;
    return d[15:8];
  endfunction

  always @(posedge clk) begin
    bs_q <= bitslip;
    for (int i = 0; i < NLANE; i++)
      if (bitslip[i] && !bs_q[i]) seen[i] <= seen[i] + 3'd1;
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < NLANE; i++)
      dout[8*i +: 8] = force_en[i] ? force_val[i] : rotl8(pat_m[i], base_rot[i] - seen[i]);
  end

  // Pulse monitor: width, re-arm gap, one-hot and busy containment.
  int run_len   [NLANE] = '{default: 0};
  int gap       [NLANE] = '{default: 0};
  bit had_fall  [NLANE] = '{default: 1'b0};
  int pulses    [NLANE] = '{default: 0};
  int width_bad [NLANE] = '{default: 0};
  int gap_bad   [NLANE] = '{default: 0};
  int hot_bad = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NLANE; i++) begin
        run_len[i]  <= 0;
        gap[i]      <= 0;
        had_fall[i] <= 1'b0;
      end
    end else begin
      if (!$onehot0(bitslip) || (bitslip != '0 && !busy)) hot_bad <= hot_bad + 1;
      for (int i = 0; i < NLANE; i++) begin
        if (bitslip[i]) begin
          run_len[i] <= run_len[i] + 1;
          if (run_len[i] == 0) begin
            pulses[i] <= pulses[i] + 1;
            if (had_fall[i] && gap[i] < SETTLE) gap_bad[i] <= gap_bad[i] + 1;
          end
        end else if (run_len[i] != 0) begin
          if (run_len[i] != PULSE_W) width_bad[i] <= width_bad[i] + 1;
          run_len[i]  <= 0;
          gap[i]      <= 1;
          had_fall[i] <= 1'b1;
        end else begin
          gap[i] <= gap[i] + 1;
        end
      end
    end
  end

  function automatic int bad_total();
    int s;
    s = hot_bad;
    for (int i = 0; i < NLANE; i++) s += width_bad[i] + gap_bad[i];
    return s;
  endfunction

  // Slips needed: first k in 0..7 at which the presented word equals the pattern; 8 means never.
  function automatic int exp_slips(input logic [7:0] p, input logic [2:0] r,
                                   input logic fe, input logic [7:0] fv);
    for (int k = 0; k < 8; k++) begin
      if (fe ? (fv == p) : (rotl8(p, r - 3'(k)) == p)) return k;
    end
    return 8;
  endfunction

  function automatic int lane_cost(input int k);
    return (k < 8) ? k * SLIP_COST + MATCH_CNT + 1 : 7 * SLIP_COST + 3;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setup_aligned(input logic [7:0] p);
    for (int i = 0; i < NLANE; i++) begin
      pat_m[i]     = p;
      base_rot[i]  = seen[i];
      force_en[i]  = 1'b0;
      force_val[i] = 8'h00;
    end
  endtask

  // mode 1: glitch lane 0 once its match counter reaches 5, restore the model after the slip.
  task automatic run_align(input string tag, input int mode);
    int exp_k [NLANE];
    int p0 [NLANE];
    logic [NLANE-1:0] exp_ok;
    int exp_cyc, n, b0;
    exp_cyc = 2;
    for (int i = 0; i < NLANE; i++) begin
      exp_k[i] = exp_slips(pat_m[i], base_rot[i] - seen[i], force_en[i], force_val[i]);
      p0[i] = pulses[i];
    end
    if (mode == 1) begin
      exp_k[0] = 1;
      exp_cyc += 6 + PULSE_W + SETTLE + MATCH_CNT + 1;
      for (int i = 1; i < NLANE; i++) exp_cyc += lane_cost(exp_k[i]);
    end else begin
      for (int i = 0; i < NLANE; i++) exp_cyc += lane_cost(exp_k[i]);
    end
    for (int i = 0; i < NLANE; i++) exp_ok[i] = (exp_k[i] < 8);
    b0 = bad_total();

    @(negedge clk);
    for (int i = 0; i < NLANE; i++) pattern[8*i +: 8] = pat_m[i];
    start = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        for (int i = 0; i < NLANE; i++) pattern[8*i +: 8] = 8'($urandom);
      end
      if (n == 20) start = 1'b1;
      if (n == 21) start = 1'b0;
      if (mode == 1 && n == 6) begin
        force_en[0]  = 1'b1;
        force_val[0] = ~pat_m[0];
      end
      if (mode == 1 && n == 7) force_en[0] = 1'b0;
      if (mode == 1 && n == 10) base_rot[0] = seen[0];
    end while (!done && n < 4000);

    check({tag, "_done"}, done, 1);
    check({tag, "_cycles"}, n, exp_cyc);
    check({tag, "_lane_ok"}, lane_ok, exp_ok);
    check({tag, "_locked"}, locked, &exp_ok);
    check({tag, "_busy_off"}, busy, 0);
    for (int i = 0; i < NLANE; i++) begin
      check($sformatf("%s_slip%0d", tag, i), slip_cnt[3*i +: 3], (exp_k[i] > 7) ? 7 : exp_k[i]);
      check($sformatf("%s_pulses%0d", tag, i), pulses[i] - p0[i], (exp_k[i] > 7) ? 7 : exp_k[i]);
    end
    check({tag, "_pulse_rules"}, bad_total() - b0, 0);
    @(negedge clk);
    check({tag, "_done_1cyc"}, done, 0);
    $display("run %s: cycles=%0d lane_ok=0x%0h locked=%0b slip_cnt=0x%0h", tag, n, lane_ok, locked, slip_cnt);
  endtask

  initial begin
    int n;
    setup_aligned(8'hA1);
    repeat (3) @(negedge clk);
    check("rst_bitslip", bitslip, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_locked", locked, 0);
    check("rst_lane_ok", lane_ok, 0);
    check("rst_slip_cnt", slip_cnt, 0);
`ifdef AD9653_BITSLIP_ALIGN_MONITOR_EN
    check("rst_err_cnt", err_cnt, 0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    setup_aligned(8'hA1);
    run_align("aligned", 0);

    setup_aligned(8'hA1);
    base_rot[3] = seen[3] + 3'd3;
    run_align("lane3_rot3", 0);

    setup_aligned(8'hA1);
    force_en[5]  = 1'b1;
    force_val[5] = 8'h00;
    run_align("lane5_dead", 0);

    setup_aligned(8'hA1);
    run_align("glitch", 1);

    // Reset in the second cycle of a bitslip pulse
    setup_aligned(8'hA1);
    base_rot[3] = seen[3] + 3'd3;
    @(negedge clk);
    for (int i = 0; i < NLANE; i++) pattern[8*i +: 8] = pat_m[i];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (bitslip == '0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_first", bitslip, 8'h08);
    @(posedge clk);
    #1;
    check("rst_mid_second", bitslip, 8'h08);
    rst_n = 1'b0;
    #1;
    check("rst_mid_bitslip", bitslip, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_slip_cnt", slip_cnt, 0);
    $display("reset mid-pulse: bitslip=0x%0h busy=%0b", bitslip, busy);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_align("post_reset", 0);

    for (int r = 0; r < 6; r++) begin
      int f, sel;
      for (int i = 0; i < NLANE; i++) begin
        sel = $urandom_range(0, 9);
        pat_m[i]     = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
        base_rot[i]  = seen[i] + 3'($urandom_range(0, 7));
        force_en[i]  = 1'b0;
        force_val[i] = 8'($urandom);
      end
      f = $urandom_range(0, NLANE);
      if (f < NLANE) force_en[f] = 1'b1;
      run_align($sformatf("rand%0d", r), 0);
    end

    // Post-lock behaviour under a 4-cycle corruption of lane 2
    setup_aligned(8'hA1);
    run_align("pre_mon", 0);
    repeat (3) @(negedge clk);
    check("mon_pre_locked", locked, 1);
`ifdef AD9653_BITSLIP_ALIGN_MONITOR_EN
    check("mon_pre_err", err_cnt, 0);
`endif
    force_en[2]  = 1'b1;
    force_val[2] = ~pat_m[2];
    repeat (4) @(negedge clk);
    force_en[2] = 1'b0;
    @(negedge clk);
`ifdef AD9653_BITSLIP_ALIGN_MONITOR_EN
    check("mon_lane_ok", lane_ok, 8'hFB);
    check("mon_locked", locked, 0);
    check("mon_err_cnt", err_cnt, 4);
    $display("monitor: lane_ok=0x%0h locked=%0b err_cnt=%0d", lane_ok, locked, err_cnt);
`else
    check("hold_lane_ok", lane_ok, 8'hFF);
    check("hold_locked", locked, 1);
    $display("hold: lane_ok=0x%0h locked=%0b", lane_ok, locked);
`endif
    run_align("after_mon", 0);
`ifdef AD9653_BITSLIP_ALIGN_MONITOR_EN
    check("mon_err_cleared", err_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
